// File: rtl/inventory_tracker.sv
// Signed Q32.32 inventory tracker: fill handshake, clamp, inhibit flags.
// Optional fill/saturation counters are enabled with INVENTORY_STATS_EN.
module inventory_tracker #(
    parameter int INV_LIMIT_LOTS = 1000,
    parameter int INHIBIT_LOTS   = 900
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fill_valid,
    output logic        o_fill_ready,
    input  logic        i_fill_side,
    input  logic [63:0] i_fill_qty,
    input  logic        i_flatten,
    output logic [63:0] o_inventory_state,
    output logic        o_inv_valid,
    output logic        o_sat,
    output logic        o_fill_err,
    output logic        o_buy_inhibit,
    output logic        o_sell_inhibit
`ifdef INVENTORY_STATS_EN
    ,
    output logic [31:0] o_buy_fills,
    output logic [31:0] o_sell_fills,
    output logic [15:0] o_sat_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_PUBLISH
    } state_t;

    localparam logic signed [63:0] C_LIM =
        {32'(INV_LIMIT_LOTS), 32'd0};
    localparam logic signed [63:0] C_INH =
        {32'(INHIBIT_LOTS), 32'd0};
    localparam logic signed [64:0] C_LIM_X = {1'b0, C_LIM};

    state_t             r_state;
    state_t             w_state_next;
    logic signed [63:0] r_inv;
    logic               r_side;
    logic [63:0]        r_qty;
    logic               r_inv_valid;
    logic               r_sat;
    logic               r_fill_err;

    logic               w_ready;
    logic               w_accept;
    logic               w_flat;
    logic               w_qty_bad;
    logic signed [64:0] w_inv_x;
    logic signed [64:0] w_qty_x;
    logic signed [64:0] w_sum;
    logic signed [63:0] w_clamped;
    logic               w_clamp;

    assign w_qty_bad = i_fill_qty[63] | (i_fill_qty == 64'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Flatten outranks a fill offered in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_flat       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = i_rst_n & ~i_flatten;
                if (i_flatten) begin
                    w_flat       = 1'b1;
                    w_state_next = S_PUBLISH;
                end else if (i_fill_valid) begin
                    w_accept = 1'b1;
                    if (!w_qty_bad) w_state_next = S_UPDATE;
                end
            end
            S_UPDATE:  w_state_next = S_PUBLISH;
            S_PUBLISH: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    assign w_inv_x = {r_inv[63], r_inv};
    assign w_qty_x = {1'b0, r_qty};
    assign w_sum   = r_side ? (w_inv_x - w_qty_x)
                            : (w_inv_x + w_qty_x);

    always_comb begin
        w_clamped = w_sum[63:0];
        w_clamp   = 1'b0;
        if (w_sum > C_LIM_X) begin
            w_clamped = C_LIM;
            w_clamp   = 1'b1;
        end else if (w_sum < -C_LIM_X) begin
            w_clamped = -C_LIM;
            w_clamp   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inv       <= '0;
            r_side      <= 1'b0;
            r_qty       <= '0;
            r_inv_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_fill_err  <= 1'b0;
        end else begin
            r_inv_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_fill_err  <= 1'b0;
            if (w_flat) begin
                r_inv       <= '0;
                r_inv_valid <= 1'b1;
            end
            if (w_accept) begin
                if (w_qty_bad) begin
                    r_fill_err <= 1'b1;
                end else begin
                    r_side <= i_fill_side;
                    r_qty  <= i_fill_qty;
                end
            end
            if (r_state == S_UPDATE) begin
                r_inv       <= w_clamped;
                r_inv_valid <= 1'b1;
                r_sat       <= w_clamp;
            end
        end
    end

`ifdef INVENTORY_STATS_EN
    logic [31:0] r_buy_fills;
    logic [31:0] r_sell_fills;
    logic [15:0] r_sat_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buy_fills  <= '0;
            r_sell_fills <= '0;
            r_sat_count  <= '0;
        end else if (r_state == S_UPDATE) begin
            if (r_side) r_sell_fills <= r_sell_fills + 32'd1;
            else        r_buy_fills  <= r_buy_fills + 32'd1;
            if (w_clamp) r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign o_buy_fills  = r_buy_fills;
    assign o_sell_fills = r_sell_fills;
    assign o_sat_count  = r_sat_count;
`endif

    assign o_fill_ready      = w_ready;
    assign o_inventory_state = r_inv;
    assign o_inv_valid       = r_inv_valid;
    assign o_sat             = r_sat;
    assign o_fill_err        = r_fill_err;
    assign o_buy_inhibit     = (r_inv >= C_INH);
    assign o_sell_inhibit    = (r_inv <= -C_INH);

endmodule

// File: tb/tb_inventory_tracker.sv
// Directed bench for inventory_tracker: vector table plus
// flatten-collision and mid-operation reset sequences.
module tb_inventory_tracker;

    logic        clk;
    logic        rst_n;
    logic        fill_valid;
    logic        fill_ready;
    logic        fill_side;
    logic [63:0] fill_qty;
    logic        flatten;
    logic [63:0] inv;
    logic        inv_valid;
    logic        sat;
    logic        fill_err;
    logic        buy_inh;
    logic        sell_inh;
`ifdef INVENTORY_STATS_EN
    logic [31:0] buy_fills;
    logic [31:0] sell_fills;
    logic [15:0] sat_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    inventory_tracker dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_fill_valid      (fill_valid),
        .o_fill_ready      (fill_ready),
        .i_fill_side       (fill_side),
        .i_fill_qty        (fill_qty),
        .i_flatten         (flatten),
        .o_inventory_state (inv),
        .o_inv_valid       (inv_valid),
        .o_sat             (sat),
        .o_fill_err        (fill_err),
        .o_buy_inhibit     (buy_inh),
        .o_sell_inhibit    (sell_inh)
`ifdef INVENTORY_STATS_EN
        ,
        .o_buy_fills       (buy_fills),
        .o_sell_fills      (sell_fills),
        .o_sat_count       (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        side;
        logic [63:0] qty;
        logic        err;
        logic [63:0] exp_inv;
        logic        exp_sat;
        logic        exp_buy;
        logic        exp_sell;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a fill and returns one cycle after the handshake edge.
    task automatic offer(input logic side,
                         input logic [63:0] qty);
        logic done;
        done       = 1'b0;
        fill_valid = 1'b1;
        fill_side  = side;
        fill_qty   = qty;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (fill_ready) begin
                done = 1'b1;
                tick();
                break;
            end
            tick();
        end
        fill_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL handshake: got timeout expected ready");
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 64'h00000064_00000000, 1'b0,
                     64'h00000064_00000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 64'h000000FA_00000000, 1'b0,
                     64'hFFFFFF6A_00000000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 64'h0000044C_00000000, 1'b0,
                     64'h000003B6_00000000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 64'h00000064_00000000, 1'b0,
                     64'h000003E8_00000000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 64'h00000001_00000000, 1'b0,
                     64'h000003E8_00000000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 64'h80000000_00000000, 1'b1,
                     64'h000003E8_00000000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 64'h00000000_00000000, 1'b1,
                     64'h000003E8_00000000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 64'h000007D0_00000000, 1'b0,
                     64'hFFFFFC18_00000000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 64'h00000000_80000000, 1'b0,
                     64'hFFFFFC18_00000000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 64'h00000064_00000000, 1'b0,
                     64'hFFFFFC7C_00000000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 64'h00000000_00000001, 1'b0,
                     64'hFFFFFC7C_00000001, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 64'h00000708_00000000, 1'b0,
                     64'h00000384_00000001, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 64'h00000190_00000001, 1'b0,
                     64'h000001F4_00000000, 1'b0, 1'b0, 1'b0};

        rst_n      = 1'b0;
        fill_valid = 1'b0;
        fill_side  = 1'b0;
        fill_qty   = '0;
        flatten    = 1'b0;
        tick();
        tick();
        chk("ready_in_reset", 64'(fill_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(fill_ready), 64'd1);
        chk("rst_inv", inv, 64'd0);
        chk("rst_flags",
            64'({inv_valid, sat, fill_err, buy_inh, sell_inh}),
            64'd0);

        for (int i = 0; i < 13; i++) begin
            offer(vecs[i].side, vecs[i].qty);
            if (vecs[i].err) begin
                chk($sformatf("v%0d_err", i), 64'(fill_err), 64'd1);
                chk($sformatf("v%0d_noval", i),
                    64'(inv_valid), 64'd0);
                chk($sformatf("v%0d_inv", i), inv, vecs[i].exp_inv);
                tick();
                chk($sformatf("v%0d_err_clr", i),
                    64'(fill_err), 64'd0);
            end else begin
                chk($sformatf("v%0d_upd", i),
                    64'({inv_valid, fill_ready}), 64'd0);
                tick();
                chk($sformatf("v%0d_valid", i),
                    64'(inv_valid), 64'd1);
                chk($sformatf("v%0d_inv", i), inv, vecs[i].exp_inv);
                chk($sformatf("v%0d_sat", i),
                    64'(sat), 64'(vecs[i].exp_sat));
                chk($sformatf("v%0d_inh", i),
                    64'({buy_inh, sell_inh}),
                    64'({vecs[i].exp_buy, vecs[i].exp_sell}));
                chk($sformatf("v%0d_pub_rdy", i),
                    64'(fill_ready), 64'd0);
                tick();
                chk($sformatf("v%0d_pulse_end", i),
                    64'({inv_valid, sat}), 64'd0);
            end
        end

`ifdef INVENTORY_STATS_EN
        chk("stat_buy", 64'(buy_fills), 64'd7);
        chk("stat_sell", 64'(sell_fills), 64'd4);
        chk("stat_sat", 64'(sat_count), 64'd3);
`endif

        // Flatten and fill offered together at +500 lots.
        flatten    = 1'b1;
        fill_valid = 1'b1;
        fill_side  = 1'b0;
        fill_qty   = 64'h0000000A_00000000;
        #1;
        chk("flat_ready", 64'(fill_ready), 64'd0);
        tick();
        flatten = 1'b0;
        chk("flat_inv", inv, 64'd0);
        chk("flat_valid", 64'(inv_valid), 64'd1);
        chk("flat_pub_rdy", 64'(fill_ready), 64'd0);
        tick();
        chk("held_ready", 64'(fill_ready), 64'd1);
        tick();
        fill_valid = 1'b0;
        chk("held_upd", 64'(inv_valid), 64'd0);
        tick();
        chk("held_valid", 64'(inv_valid), 64'd1);
        chk("held_inv", inv, 64'h0000000A_00000000);
        tick();

        // Reset one cycle after a fill handshake.
        offer(1'b0, 64'h00000005_00000000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inv", inv, 64'd0);
        chk("mid_rst_rdy", 64'(fill_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rst_noval", 64'(inv_valid), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", 64'(fill_ready), 64'd1);
        tick();
        chk("post_rst_noval", 64'(inv_valid), 64'd0);
        chk("post_rst_inv", inv, 64'd0);
        offer(1'b0, 64'h00000007_00000000);
        tick();
        chk("post_rst_valid", 64'(inv_valid), 64'd1);
        chk("post_rst_fill", inv, 64'h00000007_00000000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inventory_tracker.md
Name: inventory_tracker

Overview:
Turns executed fills from the exchange-side fill decoder into the signed inventory state that drives the order-quantity path. Accepts fills through a valid/ready handshake, applies buy (+) or sell (-) in Q32.32, clamps at a configured position limit, and publishes the updated inventory with a one-cycle valid pulse. Also drives buy/sell inhibit flags for the quoting logic and supports a flatten command that zeroes the position.

Parameters:
INV_LIMIT_LOTS, 1000, symmetric absolute position limit in whole lots; the Q32.32 limit is INV_LIMIT_LOTS<<32.
INHIBIT_LOTS, 900, absolute inventory in whole lots at which the inhibit flags assert.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_fill_valid  in  1  fill present
o_fill_ready  out  1  tracker can accept a fill
i_fill_side  in  1  0 = buy (inventory increases), 1 = sell (inventory decreases)
i_fill_qty  in  64  unsigned fill quantity, Q32.32
i_flatten  in  1  single-cycle request to force inventory to zero
o_inventory_state  out  64  signed inventory, Q32.32, two's complement
o_inv_valid  out  1  one-cycle pulse when o_inventory_state has been updated
o_sat  out  1  one-cycle pulse, aligned with o_inv_valid, when the update was clamped
o_fill_err  out  1  one-cycle pulse when a fill is rejected
o_buy_inhibit  out  1  level: inventory >= +INHIBIT_LOTS<<32
o_sell_inhibit  out  1  level: inventory <= -(INHIBIT_LOTS<<32)

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except o_fill_ready. State is IDLE. o_fill_ready is 0 during reset and 1 in the first cycle after release.
- FSM states: IDLE, UPDATE, PUBLISH.
- IDLE:
  - o_fill_ready = !i_flatten.
  - If i_flatten is high: inventory_next = 0, go to PUBLISH. Flatten has priority; a fill offered in the same cycle is not accepted and must be held.
  - Else, if i_fill_valid is high, the fill is accepted (handshake = valid & ready). Capture side and qty, go to UPDATE.
- Fill rejection: an accepted fill with i_fill_qty[63] = 1 or i_fill_qty = 0:
  - pulses o_fill_err the next cycle;
  - returns to IDLE;
  - leaves inventory unchanged and produces no o_inv_valid.
- UPDATE (o_fill_ready = 0):
  - Compute a 65-bit signed sum: inv ± qty.
  - Clamp the result to [-(INV_LIMIT_LOTS<<32), +(INV_LIMIT_LOTS<<32)].
  - Set a sat flag if the result was clamped. Go to PUBLISH.
- PUBLISH (o_fill_ready = 0):
  - Register o_inventory_state.
  - Pulse o_inv_valid, and o_sat if the sat flag is set.
  - Return to IDLE.
- Latency: fill accepted at cycle N; o_inventory_state and o_inv_valid change at cycle N+2. Flatten requested at cycle N; update at N+1. Fill throughput is 1 per 3 cycles.
- i_flatten outside IDLE is ignored; the requester must hold it until a cycle with o_fill_ready = 1 or state IDLE.
- o_inventory_state holds its value between updates.
- Inhibit flags are combinational from the registered o_inventory_state and update in the same cycle as o_inv_valid.
- Exact limit: a result exactly equal to ±limit is not saturated; o_sat = 0.
- Reset mid-operation: any in-flight fill is discarded and inventory returns to 0.

Optional Feature:
INVENTORY_STATS_EN
- When defined, adds three outputs:
  - o_buy_fills: 32-bit count of applied buy fills;
  - o_sell_fills: 32-bit count of applied sell fills;
  - o_sat_count: 16-bit count of saturation events.
- All three counters reset to 0, wrap on overflow, and are not cleared by flatten. Rejected fills are not counted.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release: o_inventory_state = 0, o_fill_ready = 1. Buy qty 0x00000064_00000000 (100 lots) -> at N+2, o_inv_valid pulse and o_inventory_state = 0x00000064_00000000; o_sat = 0.
- From +100 lots, sell 250 lots (0x000000FA_00000000) -> o_inventory_state = 0xFFFFFF6A_00000000 (-150 lots); o_sell_inhibit = 0.
- From +950 lots, buy 100 lots -> clamped to 0x000003E8_00000000, o_sat pulses with o_inv_valid, o_buy_inhibit = 1. Next buy of 1 lot -> still +1000, o_sat pulses again.
- Fill with qty 0x80000000_00000000 -> o_fill_err pulse, no o_inv_valid, inventory unchanged. Fill with qty 0 -> same response.
- i_flatten and i_fill_valid high together in IDLE at +500 lots -> fill not accepted that cycle, o_inventory_state = 0 next cycle. The held fill is then accepted and applied from 0.
- Assert i_rst_n low one cycle after a fill handshake -> no o_inv_valid. After release, inventory = 0 and FSM is in IDLE.
